// File: rtl/config_word_receiver.sv
// config_word_receiver
//   Front end of the eFPGA configuration path. Receives 8N1 UART bytes on Rx,
//   hunts for a 32-bit sync word, takes the next byte as the session command,
//   then packs every following group of four bytes MSB-first into WriteData
//   with a one-cycle WriteStrobe.
//
// Ports
//   CLK          system clock
//   resetn       async active-low reset
//   Rx           UART serial input, idle high, asynchronous to CLK
//   WriteData    last assembled word, MSB = first received byte
//   WriteStrobe  one-cycle pulse, WriteData valid in the same cycle
//   ComActive    high while a session is open
//   Command      command byte of the current/last session
//   ReceiveLED   toggles on every WriteStrobe
//   FrameError   one-cycle pulse on a bad stop bit
module config_word_receiver #(
  parameter int unsigned BaudDivisor   = 217,
  parameter logic [31:0] SyncWord      = 32'hFAB0_FAB1,
  parameter int unsigned TimeoutCycles = 1_000_000
) (
  input  logic        CLK,
  input  logic        resetn,
  input  logic        Rx,
  output logic [31:0] WriteData,
  output logic        WriteStrobe,
  output logic        ComActive,
  output logic [7:0]  Command,
  output logic        ReceiveLED,
  output logic        FrameError
);

  localparam int BW = $clog2(BaudDivisor + 1);
  localparam int TW = $clog2(TimeoutCycles + 1);
  localparam logic [BW-1:0] BAUD_FULL = BW'(BaudDivisor);
  localparam logic [BW-1:0] BAUD_HALF = BW'(BaudDivisor / 2);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  // idle_q == TO_LAST marks the TimeoutCycles-th idle cycle after a byte
  localparam logic [TW-1:0] TO_LAST   = TW'(TimeoutCycles - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;
  typedef enum logic [1:0] {HUNT, CMD, WORDS} pkt_state_e;

  // ---------------- Rx synchroniser (resets to line idle) ----------------
  logic rx_meta_q, rx_s_q;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= Rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // ---------------- Bit FSM ----------------
  rx_state_e       rx_state_q;
  logic [BW-1:0]   baud_q;
  logic [2:0]      bit_q;
  logic [7:0]      rx_shift_q;   // holds the last byte until the next start bit
  logic            byte_valid_q;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      rx_state_q   <= RX_IDLE;
      baud_q       <= '0;
      bit_q        <= '0;
      rx_shift_q   <= '0;
      byte_valid_q <= 1'b0;
      FrameError   <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      FrameError   <= 1'b0;
      case (rx_state_q)
        RX_IDLE: if (!rx_s_q) begin
          rx_state_q <= RX_START;
          baud_q     <= BAUD_HALF;
        end
        RX_START: begin
          if (baud_q == BAUD_ONE) begin
            // Line back high at mid start bit: treat as a glitch
            if (rx_s_q) rx_state_q <= RX_IDLE;
            else begin
              rx_state_q <= RX_DATA;
              baud_q     <= BAUD_FULL;
              bit_q      <= '0;
            end
          end else baud_q <= baud_q - 1'b1;
        end
        RX_DATA: begin
          if (baud_q == BAUD_ONE) begin
            rx_shift_q <= {rx_s_q, rx_shift_q[7:1]};   // LSB first
            baud_q     <= BAUD_FULL;
            bit_q      <= bit_q + 3'd1;
            if (bit_q == 3'd7) rx_state_q <= RX_STOP;
          end else baud_q <= baud_q - 1'b1;
        end
        RX_STOP: begin
          if (baud_q == BAUD_ONE) begin
            if (rx_s_q) begin
              byte_valid_q <= 1'b1;
              rx_state_q   <= RX_IDLE;
            end else begin
              FrameError <= 1'b1;
              rx_state_q <= RX_WAIT;   // don't mistake a low stop bit for a start bit
            end
          end else baud_q <= baud_q - 1'b1;
        end
        RX_WAIT: if (rx_s_q) rx_state_q <= RX_IDLE;
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // ---------------- Packet FSM ----------------
  pkt_state_e    pkt_q;
  logic [31:0]   win_q;
  logic [23:0]   word_shift_q;
  logic [1:0]    wcnt_q;
  logic [TW-1:0] idle_q;
  logic [31:0]   win_next;

  assign win_next = {win_q[23:0], rx_shift_q};

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      pkt_q        <= HUNT;
      win_q        <= '0;
      word_shift_q <= '0;
      wcnt_q       <= '0;
      idle_q       <= '0;
      WriteData    <= '0;
      WriteStrobe  <= 1'b0;
      ComActive    <= 1'b0;
      Command      <= '0;
      ReceiveLED   <= 1'b0;
    end else begin
      WriteStrobe <= 1'b0;
      case (pkt_q)
        HUNT: begin
          idle_q <= '0;
          if (byte_valid_q) begin
            win_q <= win_next;
            if (win_next == SyncWord) begin
              ComActive <= 1'b1;
              pkt_q     <= CMD;
            end
          end else if (FrameError) begin
            win_q <= '0;
          end
        end
        default: begin   // CMD / WORDS: session open
          // A byte arriving on the timeout cycle keeps the session alive
          if (byte_valid_q) begin
            idle_q <= '0;
            if (pkt_q == CMD) begin
              Command <= rx_shift_q;
              wcnt_q  <= '0;
              pkt_q   <= WORDS;
            end else begin
              word_shift_q <= {word_shift_q[15:0], rx_shift_q};
              wcnt_q       <= wcnt_q + 2'd1;
              if (wcnt_q == 2'd3) begin
                WriteData   <= {word_shift_q, rx_shift_q};
                WriteStrobe <= 1'b1;
                ReceiveLED  <= ~ReceiveLED;
              end
            end
          end else if (FrameError || idle_q == TO_LAST) begin
            ComActive    <= 1'b0;
            pkt_q        <= HUNT;
            win_q        <= '0;
            word_shift_q <= '0;
            wcnt_q       <= '0;
            idle_q       <= '0;
          end else begin
            idle_q <= idle_q + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
